// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: producer/consumer handshake bundle for stream_mux_rr.
// STREAM_MUX_PKT_LOCK_EN adds the in_last/out_last packet delimiters.
interface stream_mux_rr_if #(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_chan;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;

  modport master (
    output sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_chan, out_last
  );
  modport slave (
    input  sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_chan, out_last
  );
`else
  modport master (
    output sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );
  modport slave (
    input  sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux, fixed select or round-robin.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant until in_last.
module stream_mux_rr #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave mux_io
);
  localparam int SEL_W = $clog2(N);

  logic [W-1:0]     ch_data [N];
  logic [N-1:0]     rdy;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] rr_idx, idx, gnt;
  logic             rr_vld, gnt_vld;
  logic             load_en, xfer, last_ok;
  logic [W-1:0]     data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;
  int               j;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = mux_io.in_data[i*W +: W];
  end

  assign load_en = rst_n && (!valid_q || mux_io.out_ready);

  // Walk the ring backwards so the last hit is the first after ptr.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    idx    = '0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      idx = SEL_W'(j);
      if (mux_io.in_valid[idx]) begin
        rr_vld = 1'b1;
        rr_idx = idx;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch_q;
  logic             last_q;

  assign last_ok         = mux_io.in_last[gnt];
  assign mux_io.out_last = last_q;
`else
  assign last_ok = 1'b1;
`endif

  always_comb begin
    if (MODE == 1) begin
      gnt     = rr_idx;
      gnt_vld = rr_vld;
    end else begin
      gnt     = mux_io.sel;
      gnt_vld = int'(mux_io.sel) < N;
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      gnt     = lock_ch_q;
      gnt_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    rdy = '0;
    if (load_en && gnt_vld) rdy[gnt] = 1'b1;
  end

  assign mux_io.in_ready = rdy;
  assign xfer = load_en && gnt_vld && mux_io.in_valid[gnt];

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 1 && xfer && last_ok) begin
      ptr_d = (int'(gnt) == N - 1) ? '0 : gnt + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      chan_q    <= '0;
      ptr_q     <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      last_q    <= 1'b0;
`endif
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        valid_q   <= 1'b1;
        data_q    <= ch_data[gnt];
        chan_q    <= gnt;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_q    <= !last_ok;
        lock_ch_q <= gnt;
        last_q    <= last_ok;
`endif
      end else if (mux_io.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign mux_io.out_data  = data_q;
  assign mux_io.out_valid = valid_q;
  assign mux_io.out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: four mux configs checked each cycle against a queue-free
// ring-search model, plus directed sequences with literal expectations.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int N_of [4] = '{8, 8, 5, 5};
  int M_of [4] = '{0, 1, 1, 0};

  logic [3:0]   sel_s  [4];
  logic [15:0]  vld_s  [4];
  logic [15:0]  last_s [4];
  logic [127:0] dat_s  [4];
  logic         ordy_s [4];

  logic [15:0] rdy_a [4];
  logic [7:0]  od_a  [4];
  logic [3:0]  oc_a  [4];
  logic        ov_a  [4];
  logic        ol_a  [4];

  int n_chk  = 0;
  int n_fail = 0;

  stream_mux_rr_if #(.N(8), .W(8)) if0 ();
  stream_mux_rr_if #(.N(8), .W(8)) if1 ();
  stream_mux_rr_if #(.N(5), .W(8)) if2 ();
  stream_mux_rr_if #(.N(5), .W(8)) if3 ();

  stream_mux_rr #(.N(8), .W(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .mux_io(if0.slave));
  stream_mux_rr #(.N(8), .W(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mux_io(if1.slave));
  stream_mux_rr #(.N(5), .W(8), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .mux_io(if2.slave));
  stream_mux_rr #(.N(5), .W(8), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .mux_io(if3.slave));

  assign if0.sel = sel_s[0][2:0];
  assign if1.sel = sel_s[1][2:0];
  assign if2.sel = sel_s[2][2:0];
  assign if3.sel = sel_s[3][2:0];
  assign if0.in_valid = vld_s[0][7:0];
  assign if1.in_valid = vld_s[1][7:0];
  assign if2.in_valid = vld_s[2][4:0];
  assign if3.in_valid = vld_s[3][4:0];
  assign if0.in_data = dat_s[0][63:0];
  assign if1.in_data = dat_s[1][63:0];
  assign if2.in_data = dat_s[2][39:0];
  assign if3.in_data = dat_s[3][39:0];
  assign if0.out_ready = ordy_s[0];
  assign if1.out_ready = ordy_s[1];
  assign if2.out_ready = ordy_s[2];
  assign if3.out_ready = ordy_s[3];

  assign rdy_a[0] = 16'(if0.in_ready);
  assign rdy_a[1] = 16'(if1.in_ready);
  assign rdy_a[2] = 16'(if2.in_ready);
  assign rdy_a[3] = 16'(if3.in_ready);
  assign od_a[0] = if0.out_data;
  assign od_a[1] = if1.out_data;
  assign od_a[2] = if2.out_data;
  assign od_a[3] = if3.out_data;
  assign oc_a[0] = 4'(if0.out_chan);
  assign oc_a[1] = 4'(if1.out_chan);
  assign oc_a[2] = 4'(if2.out_chan);
  assign oc_a[3] = 4'(if3.out_chan);
  assign ov_a[0] = if0.out_valid;
  assign ov_a[1] = if1.out_valid;
  assign ov_a[2] = if2.out_valid;
  assign ov_a[3] = if3.out_valid;

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign if0.in_last = last_s[0][7:0];
  assign if1.in_last = last_s[1][7:0];
  assign if2.in_last = last_s[2][4:0];
  assign if3.in_last = last_s[3][4:0];
  assign ol_a[0] = if0.out_last;
  assign ol_a[1] = if1.out_last;
  assign ol_a[2] = if2.out_last;
  assign ol_a[3] = if3.out_last;
`else
  assign ol_a = '{default: 1'b0};
`endif

  // Reference model state: held beat, ring pointer, packet lock.
  bit       m_vld  [4];
  bit [7:0] m_dat  [4];
  int       m_ch   [4];
  bit       m_last [4];
  int       m_ptr  [4];
  bit       m_lock [4];
  int       m_lch  [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant(int d);
    int n;
    n = N_of[d];
    if (m_lock[d]) return m_lch[d];
    if (M_of[d] == 0) return (int'(sel_s[d]) < n) ? int'(sel_s[d]) : -1;
    for (int k = 0; k < n; k++)
      if (vld_s[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    return -1;
  endfunction

  function automatic logic [15:0] exp_rdy(int d);
    int g;
    if (!rst_n) return 16'h0;
    g = exp_grant(d);
    if (g < 0 || !(!m_vld[d] || ordy_s[d])) return 16'h0;
    return 16'h1 << g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 4; d++) begin
      if (!rst_n) begin
        m_vld[d]  <= 1'b0;
        m_dat[d]  <= 8'h0;
        m_ch[d]   <= 0;
        m_last[d] <= 1'b0;
        m_ptr[d]  <= 0;
        m_lock[d] <= 1'b0;
        m_lch[d]  <= 0;
      end else begin
        int g;
        g = exp_grant(d);
        if (g >= 0 && (!m_vld[d] || ordy_s[d]) && vld_s[d][g]) begin
          m_vld[d]  <= 1'b1;
          m_dat[d]  <= dat_s[d][g*8 +: 8];
          m_ch[d]   <= g;
          m_last[d] <= last_s[d][g];
`ifdef STREAM_MUX_PKT_LOCK_EN
          m_lock[d] <= !last_s[d][g];
          m_lch[d]  <= g;
          if (M_of[d] == 1 && last_s[d][g])
            m_ptr[d] <= (g + 1) % N_of[d];
`else
          if (M_of[d] == 1) m_ptr[d] <= (g + 1) % N_of[d];
`endif
        end else if (ordy_s[d] && m_vld[d]) begin
          m_vld[d] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("m_valid%0d", d), 32'(ov_a[d]), 32'(m_vld[d]));
      chk($sformatf("m_data%0d", d), 32'(od_a[d]), 32'(m_dat[d]));
      chk($sformatf("m_chan%0d", d), 32'(oc_a[d]), 32'(m_ch[d]));
      chk($sformatf("m_rdy%0d", d), 32'(rdy_a[d]), 32'(exp_rdy(d)));
`ifdef STREAM_MUX_PKT_LOCK_EN
      chk($sformatf("m_last%0d", d), 32'(ol_a[d]), 32'(m_last[d]));
`endif
    end
  end

  initial begin
    int wexp [4];
    int lexp [5];
    wexp = '{4, 1, 4, 1};
    lexp = '{2, 2, 2, 5, 0};
    for (int d = 0; d < 4; d++) begin
      sel_s[d]  = 4'h0;
      vld_s[d]  = 16'h0;
      last_s[d] = 16'hFFFF;
      dat_s[d]  = '0;
      ordy_s[d] = 1'b1;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_valid", 32'(ov_a[d]), 32'd0);
      chk("rst_data", 32'(od_a[d]), 32'd0);
      chk("rst_chan", 32'(oc_a[d]), 32'd0);
      chk("rst_rdy", 32'(rdy_a[d]), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Fixed select and backpressure on the 8-way fixed mux.
    sel_s[0] = 4'd3;
    vld_s[0] = 16'h08;
    dat_s[0][31:24] = 8'hA5;
    @(negedge clk);
    chk("fix_rdy", 32'(rdy_a[0]), 32'h08);
    @(posedge clk); #1;
    ordy_s[0] = 1'b0;
    vld_s[0]  = 16'h28;
    dat_s[0][47:40] = 8'h5A;
    sel_s[0]  = 4'd5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov_a[0]), 32'd1);
      chk("bp_data", 32'(od_a[0]), 32'hA5);
      chk("bp_chan", 32'(oc_a[0]), 32'd3);
      chk("bp_rdy", 32'(rdy_a[0]), 32'd0);
      @(posedge clk); #1;
      sel_s[0] = (c % 2 == 0) ? 4'd3 : 4'd5;
    end
    ordy_s[0] = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 32'(rdy_a[0]), 32'h20);
    chk("rel_valid", 32'(ov_a[0]), 32'd1);
    @(posedge clk); #1 vld_s[0] = 16'h0;
    @(negedge clk);
    chk("rel_data", 32'(od_a[0]), 32'h5A);
    chk("rel_chan", 32'(oc_a[0]), 32'd5);

    // Round-robin over 8 busy channels.
    vld_s[1] = 16'hFF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 9) vld_s[1] = 16'h0;
      @(negedge clk);
      chk("rr_valid", 32'(ov_a[1]), 32'd1);
      chk("rr_chan", 32'(oc_a[1]), 32'(c % 8));
    end

    // 5-way ring wrap: move ptr to 2, then only 1 and 4 contend.
    vld_s[2] = 16'h02;
    @(posedge clk); #1 vld_s[2] = 16'h12;
    @(negedge clk);
    chk("wrap_pre", 32'(oc_a[2]), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 3) vld_s[2] = 16'h0;
      @(negedge clk);
      chk("wrap_chan", 32'(oc_a[2]), 32'(wexp[c]));
    end

    // Random traffic on all four muxes.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        vld_s[d]  = (c % 200 < 100) ? 16'($urandom)
                                    : 16'($urandom) & 16'($urandom);
        last_s[d] = 16'($urandom) | 16'($urandom);
        sel_s[d]  = 4'($urandom_range(0, 7));
        ordy_s[d] = ($urandom % 4) != 0;
        dat_s[d]  = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    // Async reset between edges with a held beat.
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      vld_s[d]  = 16'h0;
      last_s[d] = 16'hFFFF;
    end
    vld_s[1]  = 16'hFF;
    ordy_s[1] = 1'b0;
    @(posedge clk); #1;
    chk("arst_pre", 32'(ov_a[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("arst_valid", 32'(ov_a[d]), 32'd0);
      chk("arst_rdy", 32'(rdy_a[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    vld_s[1]  = 16'h01;
    ordy_s[1] = 1'b1;
    @(posedge clk); #1 vld_s[1] = 16'h0;
    @(negedge clk);
    chk("arst_valid2", 32'(ov_a[1]), 32'd1);
    chk("arst_chan", 32'(oc_a[1]), 32'd0);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Three-beat packet on ch2 holds off ch0 and ch5 (ptr is 1 here).
    vld_s[1]  = 16'h25;
    last_s[1] = 16'hFFFB;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) last_s[1] = 16'hFFFF;
      if (c == 2) vld_s[1] = 16'h21;
      if (c == 4) vld_s[1] = 16'h0;
      @(negedge clk);
      chk("lock_chan", 32'(oc_a[1]), 32'(lexp[c]));
    end
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Selects one source per cycle, either by an external select (fixed mode) or by round-robin arbitration.
- The selected beat is registered into a single-entry output stage.
- Sits between multiple producer streams and one consumer; it is the clocked, handshaked successor of the team's 8:1 bit mux.

Parameters:
- N, 8, number of input channels (2..16; need not be a power of two).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N), width of sel and out_chan; derived, never overridden.
- MODE, 0, 0 = fixed select via sel, 1 = round-robin arbitration (sel ignored).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  SEL_W  channel select, used only when MODE=0.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit is high in any cycle.
- out_data  out  W  registered output beat.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_chan  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- One clock (clk); rst_n is asynchronous assert and active-low.
- Reset values: out_valid=0, out_data=0, out_chan=0, RR pointer ptr=0, in_ready=0.
- Reset asserted mid-operation discards any held beat immediately.
- load_en = !out_valid || out_ready. The stage accepts a new beat in the same cycle the old one drains, giving full throughput of 1 beat/cycle.
- Grant, fixed mode (MODE=0):
  - grant = sel.
  - If sel >= N (non-power-of-two N), no grant is made and all in_ready are 0.
- Grant, round-robin (MODE=1):
  - grant = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - No grant if no in_valid bit is set.
- in_ready[grant] = load_en && grant exists; all other in_ready bits are 0.
  - in_ready is combinational from out_ready, in_valid, ptr and sel.
- Transfer on channel g (in_valid[g] && in_ready[g]) at a rising edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In MODE=1, ptr <= (g+1) mod N, wrapping correctly for non-power-of-two N.
- No transfer && out_ready && out_valid: out_valid <= 0; out_data and out_chan hold their values.
- out_valid && !out_ready: out_data and out_chan are stable, and no in_ready is asserted.
- Latency: 1 cycle from input handshake to out_valid.
- Changing sel while the output is stalled has no effect on the held beat.
- ptr changes only on a transfer, never on idle cycles.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (in, N) and out_last (out, 1); out_last is registered with out_data and resets to 0.
  - After a transfer from channel g with in_last[g]=0, the grant is locked to g, overriding both sel and RR, until a beat with in_last[g]=1 transfers.
  - ptr advances only on that last beat.
- Not defined: no last ports; grant is re-evaluated every beat as above.

Test Plan:
- Reset, then MODE=0, N=8, W=8, sel=3, in_valid=8'h08, in_data[3]=8'hA5, out_ready=1 -> in_ready=8'h08; next cycle out_valid=1, out_data=8'hA5, out_chan=3.
- Backpressure: hold out_ready=0 with out_valid=1 for 4 cycles while sel toggles 3->5 -> out_data/out_chan stay stable and in_ready=0; on release, the channel-5 beat loads the same cycle the old beat drains.
- Round-robin: MODE=1, all in_valid=1, out_ready=1 for 10 cycles -> out_chan sequence 0,1,...,7,0,1 at 1 beat/cycle.
- RR wrap with N=5: only channels 1 and 4 valid, ptr=2 -> grants 4, 1, 4, 1; ptr never exceeds 4.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> out_valid=0, ptr=0 immediately; after release, grant restarts at channel 0.
- STREAM_MUX_PKT_LOCK_EN, MODE=1: ch2 sends 3 beats (last on beat 3) while ch0 and ch5 are valid -> out_chan 2,2,2, then 5, then 0.
